// File: rtl/imem_pkg.sv
// ---------------------------------------------------------------------------
// imem_pkg
//
// Shared types and constants for the instruction-memory controller.
//   imem_state_e        : controller mode (BOOT while the loader streams the
//                         boot image, RUN once the core is allowed to fetch)
//   IMEM_NOP            : instruction returned for out-of-range fetches
//                         (addi x0, x0, 0)
//   IMEM_WORDS_DEFAULT  : default memory depth in 32-bit words
//   STARVE_CNT_W        : width of the loader starvation counter
//   word_oor()          : out-of-range test on a word index
// ---------------------------------------------------------------------------
package imem_pkg;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } imem_state_e;

    localparam logic [31:0] IMEM_NOP           = 32'h0000_0013;
    localparam int unsigned IMEM_WORDS_DEFAULT = 1024;
    localparam int unsigned STARVE_CNT_W       = 3;

    // Takes the word index (byte address [31:2]) so that the two low byte
    // address bits never take part in the range decision.
    function automatic logic word_oor(input logic [29:0] word_idx,
                                      input int unsigned words);
        return ({2'b00, word_idx} >= words);
    endfunction

endpackage

// File: rtl/imem_starve_cnt.sv
// ---------------------------------------------------------------------------
// imem_starve_cnt
//
// Saturating counter that tracks how many consecutive cycles a pending
// loader write has lost arbitration to the fetch port.
//
// Parameters:
//   STARVE_LIMIT : count at which at_limit_o asserts (must fit in 3 bits)
//
// Ports:
//   clk        in  1  clock, rising edge
//   rst_n      in  1  asynchronous active-low reset
//   clr_i      in  1  clear the count (dominates inc_i)
//   inc_i      in  1  increment the count; holds once STARVE_LIMIT reached
//   at_limit_o out 1  count has reached STARVE_LIMIT
// ---------------------------------------------------------------------------
module imem_starve_cnt
    import imem_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic inc_i,
    output logic at_limit_o
);

    localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

    logic [STARVE_CNT_W-1:0] cnt_q;
    logic [STARVE_CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q < LIMIT)) begin
            cnt_d = cnt_q + STARVE_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_limit_o = (cnt_q >= LIMIT);

endmodule

// File: rtl/imem_ctrl.sv
// ---------------------------------------------------------------------------
// imem_ctrl
//
// Owns the single address/write port of the instruction memory and shares
// it between the core fetch stage and a boot/patch loader.
//
// Build option:
//   IMEM_CTRL_BOOT_EN  defined   : reset enters BOOT; the core is stalled and
//                                  the loader owns the port until ld_done.
//                      undefined : no BOOT state; reset enters RUN and the
//                                  memory relies on its preload image.
//
// Parameters:
//   IMEM_WORDS   : memory depth in 32-bit words
//   STARVE_LIMIT : consecutive lost cycles after which a loader write is
//                  forced through ahead of fetch
//
// Ports:
//   clk          in  1   clock, rising edge
//   rst_n        in  1   asynchronous active-low reset
//   fetch_req    in  1   core fetch request
//   fetch_addr   in  32  fetch byte address
//   fetch_gnt    out 1   fetch accepted this cycle (combinational)
//   fetch_rvalid out 1   fetch_rdata valid (one cycle after grant)
//   fetch_rdata  out 32  fetched instruction
//   ld_valid     in  1   loader write pending
//   ld_addr      in  32  loader write byte address
//   ld_data      in  32  loader write data
//   ld_be        in  4   loader byte enables
//   ld_ready     out 1   loader write accepted this cycle (combinational)
//   ld_done      in  1   boot image complete (sampled in BOOT only)
//   core_stall   out 1   core must not fetch
//   err_oor      out 1   sticky out-of-range access flag
//   mem_a        out 32  memory byte address (word index in [31:2])
//   mem_wd       out 32  memory write data
//   mem_wm       out 4   memory byte write mask, 0 = read
//   mem_rd       in  32  memory read data (combinational from mem_a)
// ---------------------------------------------------------------------------
module imem_ctrl
    import imem_pkg::*;
#(
    parameter int unsigned IMEM_WORDS   = IMEM_WORDS_DEFAULT,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_req,
    input  logic [31:0] fetch_addr,
    output logic        fetch_gnt,
    output logic        fetch_rvalid,
    output logic [31:0] fetch_rdata,
    input  logic        ld_valid,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_data,
    input  logic [3:0]  ld_be,
    output logic        ld_ready,
    input  logic        ld_done,
    output logic        core_stall,
    output logic        err_oor,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    output logic [3:0]  mem_wm,
    input  logic [31:0] mem_rd
);

    // -----------------------------------------------------------------------
    // Mode state
    // -----------------------------------------------------------------------
    imem_state_e state;

`ifdef IMEM_CTRL_BOOT_EN
    imem_state_e state_q;
    imem_state_e state_d;

    // ld_done only matters while booting; a write presented in the same
    // cycle is still granted by the BOOT arbitration below.
    always_comb begin
        state_d = state_q;
        if ((state_q == BOOT) && ld_done) begin
            state_d = RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;
`else
    logic unused_ld_done;

    assign state          = RUN;
    assign unused_ld_done = ld_done;
`endif

    // -----------------------------------------------------------------------
    // Address decode
    // -----------------------------------------------------------------------
    logic        fetch_oor;
    logic        ld_oor;
    logic [31:0] fetch_word_addr;
    logic [31:0] ld_word_addr;
    logic        unused_addr_lsb;

    assign fetch_oor       = word_oor(fetch_addr[31:2], IMEM_WORDS);
    assign ld_oor          = word_oor(ld_addr[31:2], IMEM_WORDS);
    assign fetch_word_addr = {fetch_addr[31:2], 2'b00};
    assign ld_word_addr    = {ld_addr[31:2], 2'b00};
    assign unused_addr_lsb = ^{fetch_addr[1:0], ld_addr[1:0]};

    // -----------------------------------------------------------------------
    // Arbitration
    // -----------------------------------------------------------------------
    logic fetch_win;
    logic ld_win;
    logic ld_rdy;
    logic starve_inc;
    logic starve_clr;
    logic starve_at_limit;

    always_comb begin
        fetch_win  = 1'b0;
        ld_win     = 1'b0;
        ld_rdy     = 1'b1;
        starve_inc = 1'b0;
        if (!rst_n) begin
            // Nothing is granted while reset is held, so a write that is
            // pending across reset never reaches the memory.
            fetch_win = 1'b0;
            ld_win    = 1'b0;
        end else if (state == BOOT) begin
            ld_win = ld_valid;
        end else if (fetch_req && !(ld_valid && starve_at_limit)) begin
            fetch_win  = 1'b1;
            ld_rdy     = 1'b0;
            starve_inc = ld_valid;
        end else begin
            ld_win = ld_valid;
        end
    end

    // An accepted write or a loader with nothing pending ends the streak.
    assign starve_clr = !ld_valid || ld_win;

    imem_starve_cnt #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (starve_clr),
        .inc_i      (starve_inc),
        .at_limit_o (starve_at_limit)
    );

    // -----------------------------------------------------------------------
    // Memory port
    // -----------------------------------------------------------------------
    // Idle cycles keep the fetch address on the port so the memory output
    // already tracks the next likely fetch.
    assign mem_a  = ld_win ? ld_word_addr : fetch_word_addr;
    assign mem_wd = ld_data;
    // Out-of-range writes are accepted (handshake completes) but masked.
    assign mem_wm = (ld_win && !ld_oor) ? ld_be : 4'h0;

    // -----------------------------------------------------------------------
    // Fetch response and error flag
    // -----------------------------------------------------------------------
    logic        rvalid_q;
    logic        rvalid_d;
    logic [31:0] rdata_q;
    logic [31:0] rdata_d;
    logic        err_q;
    logic        err_d;

    always_comb begin
        rvalid_d = fetch_win;
        rdata_d  = rdata_q;
        if (fetch_win) begin
            rdata_d = fetch_oor ? IMEM_NOP : mem_rd;
        end
        err_d = err_q | (fetch_win & fetch_oor) | (ld_win & ld_oor);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q <= 1'b0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign fetch_gnt    = fetch_win;
    assign ld_ready     = ld_rdy;
    assign fetch_rvalid = rvalid_q;
    assign fetch_rdata  = rdata_q;
    assign err_oor      = err_q;
    assign core_stall   = (state == BOOT);

endmodule

// File: tb/tb_imem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_imem_ctrl
//
// Directed bench for imem_ctrl with a behavioural 1024-word memory attached
// to the memory port. Works with or without IMEM_CTRL_BOOT_EN defined.
// ---------------------------------------------------------------------------
module tb_imem_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_gnt;
    logic        fetch_rvalid;
    logic [31:0] fetch_rdata;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;
    logic [3:0]  ld_be;
    logic        ld_ready;
    logic        ld_done;
    logic        core_stall;
    logic        err_oor;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [3:0]  mem_wm;
    logic [31:0] mem_rd;

    always #5 clk = ~clk;

    imem_ctrl #(
        .IMEM_WORDS   (1024),
        .STARVE_LIMIT (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fetch_req    (fetch_req),
        .fetch_addr   (fetch_addr),
        .fetch_gnt    (fetch_gnt),
        .fetch_rvalid (fetch_rvalid),
        .fetch_rdata  (fetch_rdata),
        .ld_valid     (ld_valid),
        .ld_addr      (ld_addr),
        .ld_data      (ld_data),
        .ld_be        (ld_be),
        .ld_ready     (ld_ready),
        .ld_done      (ld_done),
        .core_stall   (core_stall),
        .err_oor      (err_oor),
        .mem_a        (mem_a),
        .mem_wd       (mem_wd),
        .mem_wm       (mem_wm),
        .mem_rd       (mem_rd)
    );

    // ---------------- behavioural memory ----------------
    // Preload: word i = 0x1000_0000 + i, except word 17 (0x44) = 0.
    logic        preload;
    logic [31:0] mem [0:1023];

    function automatic logic [31:0] init_word(input int i);
        return (i == 17) ? 32'h0 : (32'h1000_0000 + 32'(i));
    endfunction

    assign mem_rd = (mem_a < 32'h1000) ? mem[mem_a[11:2]] : 32'hBAAD_F00D;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
        end else if (mem_a < 32'h1000) begin
            for (int b = 0; b < 4; b++)
                if (mem_wm[b]) mem[mem_a[11:2]][8*b +: 8] <= mem_wd[8*b +: 8];
        end
    end

    // ---------------- checking ----------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic fr, input logic [31:0] fa, input logic lv,
                         input logic [31:0] la, input logic [31:0] ldat, input logic [3:0] be);
        fetch_req  = fr;
        fetch_addr = fa;
        ld_valid   = lv;
        ld_addr    = la;
        ld_data    = ldat;
        ld_be      = be;
    endtask

    typedef struct {
        logic        fr;
        logic [31:0] fa;
        logic        lv;
        logic [31:0] la;
        logic [31:0] ld;
        logic [3:0]  be;
        logic        e_gnt;
        logic        e_rdy;
        logic [3:0]  e_wm;
        logic [31:0] e_a;
        logic        e_rv;
        logic [31:0] e_rd;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic fr, input logic [31:0] fa, input logic lv,
                                input logic [31:0] la, input logic [31:0] ld, input logic [3:0] be,
                                input logic e_gnt, input logic e_rdy, input logic [3:0] e_wm,
                                input logic [31:0] e_a, input logic e_rv, input logic [31:0] e_rd,
                                input logic e_err);
        vec_t v;
        v.fr = fr; v.fa = fa; v.lv = lv; v.la = la; v.ld = ld; v.be = be;
        v.e_gnt = e_gnt; v.e_rdy = e_rdy; v.e_wm = e_wm; v.e_a = e_a;
        v.e_rv = e_rv; v.e_rd = e_rd; v.e_err = e_err;
        return v;
    endfunction

    initial begin
        vec_t v;
        logic exp_gnt;

        //         fr fa         lv la         data          be     gnt rdy wm     a          rv rdata          err
        vecs.push_back(mk(1, 32'h10,   0, 32'h0,    32'h0,        4'h0,  1, 0, 4'h0, 32'h10,   1, 32'h1000_0004, 0));
        vecs.push_back(mk(1, 32'h13,   0, 32'h0,    32'h0,        4'h0,  1, 0, 4'h0, 32'h10,   1, 32'h1000_0004, 0));
        vecs.push_back(mk(0, 32'h1B,   0, 32'h0,    32'h0,        4'h0,  0, 1, 4'h0, 32'h18,   0, 32'h1000_0004, 0));
        vecs.push_back(mk(0, 32'h18,   1, 32'h20,   32'hDEADBEEF, 4'hF,  0, 1, 4'hF, 32'h20,   0, 32'h1000_0004, 0));
        vecs.push_back(mk(0, 32'h18,   1, 32'h26,   32'h11223344, 4'h3,  0, 1, 4'h3, 32'h24,   0, 32'h1000_0004, 0));
        vecs.push_back(mk(1, 32'h20,   0, 32'h0,    32'h0,        4'h0,  1, 0, 4'h0, 32'h20,   1, 32'hDEADBEEF,  0));
        vecs.push_back(mk(1, 32'h24,   0, 32'h0,    32'h0,        4'h0,  1, 0, 4'h0, 32'h24,   1, 32'h1000_3344, 0));
        vecs.push_back(mk(1, 32'h20,   1, 32'h28,   32'h55,       4'hF,  1, 0, 4'h0, 32'h20,   1, 32'hDEADBEEF,  0));
        vecs.push_back(mk(1, 32'h10,   0, 32'h0,    32'h0,        4'h0,  1, 0, 4'h0, 32'h10,   1, 32'h1000_0004, 0));
        vecs.push_back(mk(1, 32'h28,   0, 32'h0,    32'h0,        4'h0,  1, 0, 4'h0, 32'h28,   1, 32'h1000_000A, 0));
        vecs.push_back(mk(1, 32'hFFC,  0, 32'h0,    32'h0,        4'h0,  1, 0, 4'h0, 32'hFFC,  1, 32'h1000_03FF, 0));
        vecs.push_back(mk(1, 32'h1000, 0, 32'h0,    32'h0,        4'h0,  1, 0, 4'h0, 32'h1000, 1, NOP,           1));
        vecs.push_back(mk(1, 32'hFFF,  0, 32'h0,    32'h0,        4'h0,  1, 0, 4'h0, 32'hFFC,  1, 32'h1000_03FF, 1));
        vecs.push_back(mk(0, 32'h0,    1, 32'h1000, 32'hCAFEF00D, 4'hF,  0, 1, 4'h0, 32'h1000, 0, 32'h1000_03FF, 1));
        vecs.push_back(mk(0, 32'h0,    1, 32'hFFC,  32'h12345678, 4'hF,  0, 1, 4'hF, 32'hFFC,  0, 32'h1000_03FF, 1));
        vecs.push_back(mk(1, 32'hFFC,  0, 32'h0,    32'h0,        4'h0,  1, 0, 4'h0, 32'hFFC,  1, 32'h1234_5678, 1));
        vecs.push_back(mk(0, 32'h0,    0, 32'h0,    32'h0,        4'h0,  0, 1, 4'h0, 32'h0,    0, 32'h1234_5678, 1));

        // ---------------- reset ----------------
        rst_n   = 1'b0;
        preload = 1'b1;
        ld_done = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        preload = 1'b0;
`ifdef IMEM_CTRL_BOOT_EN
        check("reset core_stall", core_stall, 1'b1);
`else
        check("reset core_stall", core_stall, 1'b0);
`endif
        check("reset fetch_gnt", fetch_gnt, 1'b0);
        check("reset fetch_rvalid", fetch_rvalid, 1'b0);
        check("reset fetch_rdata", fetch_rdata, 32'h0);
        check("reset ld_ready", ld_ready, 1'b1);
        check("reset err_oor", err_oor, 1'b0);
        check("reset mem_wm", mem_wm, 4'h0);
        $display("reset applied");
        @(negedge clk);
        rst_n = 1'b1;

`ifdef IMEM_CTRL_BOOT_EN
        // ---------------- boot load ----------------
        drive(1, 32'h10, 1, 32'h44, 32'h11223344, 4'b0011);
        #1;
        check("boot1 core_stall", core_stall, 1'b1);
        check("boot1 fetch_gnt", fetch_gnt, 1'b0);
        check("boot1 ld_ready", ld_ready, 1'b1);
        check("boot1 mem_wm", mem_wm, 4'h3);
        @(posedge clk); #1;
        check("boot1 rvalid", fetch_rvalid, 1'b0);
        $display("boot write 0x44 be=3");
        @(negedge clk);
        drive(1, 32'h10, 1, 32'h40, 32'hDEADBEEF, 4'hF);
        ld_done = 1'b1;
        #1;
        check("boot2 core_stall", core_stall, 1'b1);
        check("boot2 fetch_gnt", fetch_gnt, 1'b0);
        check("boot2 mem_wm", mem_wm, 4'hF);
        @(posedge clk); #1;
        check("boot2 stall falls", core_stall, 1'b0);
        $display("boot write 0x40 with ld_done");
        @(negedge clk);
        ld_done = 1'b0;
        drive(1, 32'h40, 0, 0, 0, 0);
        #1;
        check("boot3 fetch_gnt", fetch_gnt, 1'b1);
        @(posedge clk); #1;
        check("boot3 rvalid", fetch_rvalid, 1'b1);
        check("boot3 rdata", fetch_rdata, 32'hDEADBEEF);
        $display("fetch 0x40 rdata=%h", fetch_rdata);
        @(negedge clk);
        drive(1, 32'h44, 0, 0, 0, 0);
        @(posedge clk); #1;
        check("boot4 rdata", fetch_rdata, 32'h0000_3344);
        $display("fetch 0x44 rdata=%h", fetch_rdata);
        @(negedge clk);
`endif

        // ---------------- table vectors ----------------
        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            drive(v.fr, v.fa, v.lv, v.la, v.ld, v.be);
            #1;
            check($sformatf("v%0d fetch_gnt", i), fetch_gnt, v.e_gnt);
            check($sformatf("v%0d ld_ready", i), ld_ready, v.e_rdy);
            check($sformatf("v%0d mem_wm", i), mem_wm, v.e_wm);
            check($sformatf("v%0d mem_a", i), mem_a, v.e_a);
            check($sformatf("v%0d core_stall", i), core_stall, 1'b0);
            @(posedge clk); #1;
            check($sformatf("v%0d rvalid", i), fetch_rvalid, v.e_rv);
            check($sformatf("v%0d rdata", i), fetch_rdata, v.e_rd);
            check($sformatf("v%0d err_oor", i), err_oor, v.e_err);
            $display("vec %0d fr=%0b fa=%h lv=%0b la=%h gnt=%0b rdy=%0b rdata=%h err=%0b",
                     i, v.fr, v.fa, v.lv, v.la, fetch_gnt, ld_ready, fetch_rdata, err_oor);
            @(negedge clk);
        end

        // ---------------- starvation ----------------
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            exp_gnt = ((i % 5) != 4);
            drive(1, 32'h10, 1, 32'h2C, 32'h77, 4'hF);
            #1;
            check($sformatf("starve%0d fetch_gnt", i), fetch_gnt, exp_gnt);
            check($sformatf("starve%0d ld_ready", i), ld_ready, !exp_gnt);
            check($sformatf("starve%0d mem_wm", i), mem_wm, exp_gnt ? 4'h0 : 4'hF);
            $display("starve cycle %0d gnt=%0b ld_ready=%0b", i, fetch_gnt, ld_ready);
            @(negedge clk);
        end
        drive(1, 32'h2C, 0, 0, 0, 0);
        @(posedge clk); #1;
        check("starve readback", fetch_rdata, 32'h77);
        $display("fetch 0x2C rdata=%h", fetch_rdata);
        @(negedge clk);

        // ---------------- reset mid-fetch ----------------
        drive(1, 32'h10, 0, 0, 0, 0);
        @(posedge clk); #1;
        check("midrst rvalid before", fetch_rvalid, 1'b1);
        #2;
        rst_n = 1'b0;
        drive(1, 32'h10, 1, 32'h30, 32'h00000BAD, 4'hF);
        #1;
        check("midrst rvalid", fetch_rvalid, 1'b0);
        check("midrst rdata", fetch_rdata, 32'h0);
        check("midrst err_oor", err_oor, 1'b0);
        check("midrst fetch_gnt", fetch_gnt, 1'b0);
        check("midrst ld_ready", ld_ready, 1'b1);
        check("midrst mem_wm", mem_wm, 4'h0);
`ifdef IMEM_CTRL_BOOT_EN
        check("midrst core_stall", core_stall, 1'b1);
`else
        check("midrst core_stall", core_stall, 1'b0);
`endif
        $display("reset asserted mid-fetch");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 32'h30, 0, 0, 0, 0);
`ifdef IMEM_CTRL_BOOT_EN
        ld_done = 1'b1;
        #1;
        check("post-rst boot gnt", fetch_gnt, 1'b0);
        check("post-rst boot stall", core_stall, 1'b1);
        @(posedge clk);
        @(negedge clk);
        ld_done = 1'b0;
`endif
        #1;
        check("post-rst fetch_gnt", fetch_gnt, 1'b1);
        check("post-rst core_stall", core_stall, 1'b0);
        @(posedge clk); #1;
        check("post-rst rvalid", fetch_rvalid, 1'b1);
        check("post-rst dropped write", fetch_rdata, 32'h1000_000C);
        check("post-rst err_oor", err_oor, 1'b0);
        $display("fetch 0x30 after reset rdata=%h", fetch_rdata);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_ctrl.md
# imem_ctrl

Controller that owns the instruction memory's single address/write port and shares it between the core's fetch stage and a boot/patch loader. After reset it holds the core stalled while the loader streams words into memory. It then switches to run mode, where fetches have priority and a starvation guard guarantees loader patches still complete. It sits between the fetch unit, the loader (UART/debug) and the instruction memory.

## Interface
Parameters:
- IMEM_WORDS, 1024, memory depth in 32-bit words; byte address range is 0 .. IMEM_WORDS*4-1.
- STARVE_LIMIT, 4, maximum consecutive cycles a pending loader write may lose to fetch before it is forced through.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- fetch_req  in  1  core requests an instruction.
- fetch_addr  in  32  byte address of the fetch.
- fetch_gnt  out  1  fetch accepted this cycle.
- fetch_rvalid  out  1  fetch_rdata valid.
- fetch_rdata  out  32  fetched instruction.
- ld_valid  in  1  loader write pending.
- ld_addr  in  32  byte address of the write.
- ld_data  in  32  write data.
- ld_be  in  4  byte enables.
- ld_ready  out  1  loader write accepted this cycle.
- ld_done  in  1  loader finished boot image (sampled in BOOT only).
- core_stall  out  1  core must not fetch.
- err_oor  out  1  sticky out-of-range access flag.
- mem_a  out  32  memory address (word index in [31:2]).
- mem_wd  out  32  memory write data.
- mem_wm  out  4  memory byte write mask; 0 means read.
- mem_rd  in  32  memory read data (combinational from mem_a).

## Operation
- States: BOOT, RUN. Reset enters BOOT.
- In BOOT:
  - core_stall=1 and fetch_gnt=0.
  - ld_ready=1.
  - ld_valid&ld_ready drives mem_a=ld_addr, mem_wd=ld_data, mem_wm=ld_be.
  - ld_done=1 moves the FSM to RUN on the next edge. A write presented in the same cycle is still performed.
- In RUN:
  - core_stall=0 and ld_done is ignored.
  - Arbitration is fetch-priority: fetch_req wins and ld_ready=0.
  - A 3-bit starvation counter increments on each cycle where ld_valid loses. When it reaches STARVE_LIMIT, the loader wins that cycle (ld_ready=1, fetch_gnt=0).
  - The counter clears whenever a loader write is accepted or ld_valid=0.
- Out-of-range access (address >= IMEM_WORDS*4):
  - Loader write: accepted, but mem_wm is forced to 0.
  - Fetch: returns 32'h00000013 (NOP).
  - Either case sets err_oor, which is cleared only by reset.
- Address bits [1:0] are ignored for both requesters.
- When idle, mem_a holds fetch_addr and mem_wm=0.

## Timing
- fetch_gnt and ld_ready are combinational from the current-cycle request inputs and state.
- Fetch latency is 1 cycle:
  - fetch_rvalid is registered high the cycle after a grant.
  - fetch_rdata is registered from mem_rd (or NOP) at the grant edge.
  - Back-to-back grants yield back-to-back rvalid.
- A loader write commits at the edge where ld_valid&ld_ready=1.
- Reset values: state=BOOT, core_stall=1, fetch_gnt=0, fetch_rvalid=0, fetch_rdata=0, ld_ready=1, err_oor=0, starvation counter=0, mem_wm=0.
- Reset mid-operation: an in-flight fetch_rvalid is cleared immediately and any pending write is dropped.

## Configuration
- IMEM_CTRL_BOOT_EN defined: behaviour as above, with reset entering BOOT.
- IMEM_CTRL_BOOT_EN undefined:
  - The BOOT state is removed and reset enters RUN.
  - Reset value of core_stall is 0 and ld_done is unused.
  - Memory relies on its preload image.

## Structure
- Package imem_pkg contains:
  - state enum imem_state_e {BOOT, RUN};
  - constant IMEM_NOP=32'h00000013;
  - default IMEM_WORDS.
- One sub-module, imem_starve_cnt: a saturating counter with clear, increment and at-limit output, parameterised by STARVE_LIMIT.

## Test plan
- Boot load: reset, then loader writes 0xDEADBEEF to 0x10 with be=4'hF and asserts ld_done. Expect core_stall to fall the next cycle, and a fetch of 0x10 to return rvalid one cycle later with rdata 0xDEADBEEF.
- Byte mask: in BOOT, write 0x11223344 with be=4'b0011 over a word preloaded with 0. Expect a later fetch to return 0x00003344.
- Starvation: in RUN, hold fetch_req=1 and ld_valid=1 continuously. Expect exactly 4 fetch grants, then one ld_ready, with the pattern repeating.
- Out of range: fetch at 0x1000 with IMEM_WORDS=1024. Expect rdata 0x00000013 and err_oor=1 staying high. Loader write to 0x1000 must leave mem_wm=0.
- Reset mid-fetch: assert rst_n low the cycle after a grant. Expect fetch_rvalid=0 and state BOOT with core_stall=1.
- Macro off: build without IMEM_CTRL_BOOT_EN. After reset expect core_stall=0, and a fetch grant in the first cycle after reset release.
